dsc_mul_ctrl: RTL and testbench

DSC_MUL_CTRL -- requirements
Module: dsc_mul_ctrl

---
 rtl/dsc_mul_ctrl.sv | 159 +++++++++++++++
 tb/tb_dsc_mul_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_ctrl.sv
// Sequencing controller for an iterative three-operand multiplier: accepts an
// operand triple, runs the multiplier until done or timeout, then presents the product.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both 1. in_valid/out_ready are sampled only then; in_ready/out_valid are
// decoded from state, so they never depend combinationally on the far side.
module dsc_mul_ctrl #(
  parameter int INPUT_WIDTH = 4,
  parameter int CNT_WIDTH   = 20,
  parameter int TIMEOUT     = 5000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INPUT_WIDTH-1:0]   a,
  input  logic [INPUT_WIDTH-1:0]   b,
  input  logic [INPUT_WIDTH-1:0]   c,
  output logic                     mul_rst,
  output logic                     mul_en,
  output logic [INPUT_WIDTH-1:0]   mul_a,
  output logic [INPUT_WIDTH-1:0]   mul_b,
  output logic [INPUT_WIDTH-1:0]   mul_c,
  input  logic [3*INPUT_WIDTH-1:0] mul_z,
  input  logic                     mul_ov,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3*INPUT_WIDTH-1:0] z,
  output logic [CNT_WIDTH-1:0]     cycles,
  output logic                     err
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_WIDTH-1:0]   counter;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  logic                   accept;
  logic                   any_zero;
  logic                   timeout_hit;

  assign accept      = in_valid && (state == IDLE);
  assign any_zero    = (a == '0) || (b == '0) || (c == '0);
  // counter holds completed RUN cycles, so +1 is the number of the current one
  assign cnt_nxt     = counter + CNT_WIDTH'(1);
  assign timeout_hit = (cnt_nxt == TIMEOUT_C);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = any_zero ? DONE : CLEAR;
        end
      end
      CLEAR: state_nxt = RUN;
      RUN: begin
        if (mul_ov || timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state only
  always_comb begin
    in_ready  = 1'b0;
    mul_rst   = 1'b1;
    mul_en    = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      RUN: begin
        mul_rst = 1'b0;
        mul_en  = 1'b1;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // operand latches, cycle counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_c   <= '0;
      z       <= '0;
      cycles  <= '0;
      err     <= 1'b0;
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mul_a <= a;
            mul_b <= b;
            mul_c <= c;
            if (any_zero) begin
              z      <= '0;
              cycles <= '0;
              err    <= 1'b0;
            end
          end
        end
        CLEAR: counter <= '0;
        RUN: begin
          // a done flag in the timeout cycle still counts as success
          if (mul_ov) begin
            z      <= mul_z;
            cycles <= cnt_nxt;
            err    <= 1'b0;
          end else if (timeout_hit) begin
            z      <= mul_z;
            cycles <= TIMEOUT_C;
            err    <= 1'b1;
          end else begin
            counter <= cnt_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_counter_bounded: assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> (counter < TIMEOUT_C));

  a_result_held: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(z) && $stable(cycles) && $stable(err)));
`endif

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// Self-checking bench for dsc_mul_ctrl: behavioural multiplier with a settable
// latency, expected-result queue, and a second instance with a short timeout.
module tb_dsc_mul_ctrl;

  localparam int W  = 4;
  localparam int CW = 20;
  localparam int EW = 1 + CW + 3*W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance signals
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0, b = '0, c = '0;
  logic           mul_rst, mul_en;
  logic [W-1:0]   mul_a, mul_b, mul_c;
  logic [3*W-1:0] mul_z;
  logic           mul_ov;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [3*W-1:0] z;
  logic [CW-1:0]  cycles;
  logic           err;

  // short-timeout instance signals
  logic           to_in_valid = 1'b0;
  logic           to_in_ready;
  logic           to_mul_rst, to_mul_en;
  logic [W-1:0]   to_mul_a, to_mul_b, to_mul_c;
  logic           to_out_valid;
  logic           to_out_ready = 1'b0;
  logic [3*W-1:0] to_z;
  logic [CW-1:0]  to_cycles;
  logic           to_err;

  dsc_mul_ctrl #(.INPUT_WIDTH(W), .CNT_WIDTH(CW), .TIMEOUT(5000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .mul_rst(mul_rst), .mul_en(mul_en),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_z(mul_z), .mul_ov(mul_ov),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .cycles(cycles), .err(err)
  );

  dsc_mul_ctrl #(.INPUT_WIDTH(W), .CNT_WIDTH(CW), .TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst), .in_valid(to_in_valid), .in_ready(to_in_ready),
    .a(4'd1), .b(4'd2), .c(4'd3), .mul_rst(to_mul_rst), .mul_en(to_mul_en),
    .mul_a(to_mul_a), .mul_b(to_mul_b), .mul_c(to_mul_c), .mul_z(12'd0), .mul_ov(1'b0),
    .out_valid(to_out_valid), .out_ready(to_out_ready), .z(to_z), .cycles(to_cycles),
    .err(to_err)
  );

  // behavioural multiplier: raises mul_ov in its lat-th enabled cycle
  int lat = 4;
  int mdl_cnt = 0;
  always @(posedge clk) begin
    if (mul_rst) mdl_cnt <= 0;
    else if (mul_en) mdl_cnt <= mdl_cnt + 1;
  end
  assign mul_ov = mul_en && (mdl_cnt == lat - 1);
  assign mul_z  = 12'(mul_a) * 12'(mul_b) * 12'(mul_c);

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int n_out    = 0;
  logic en_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mul_en) en_seen = 1'b1;
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 64'(1), 64'(0));
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("sb_z",      64'(z),      64'(e[3*W-1:0]));
        check("sb_cycles", 64'(cycles), 64'(e[3*W +: CW]));
        check("sb_err",    64'(err),    64'(e[EW-1]));
      end
    end
  end

  // driver: offer a triple until accepted; in_valid is left high
  task automatic drive_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vc);
    logic ok;
    logic [3*W-1:0] ez;
    logic [CW-1:0]  ec;
    ok = 1'b0;
    @(posedge clk); #1;
    a = va; b = vb; c = vc;
    in_valid = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 64'(0), 64'(1));
    else begin
      if (va == 0 || vb == 0 || vc == 0) begin
        ez = '0;
        ec = '0;
      end else begin
        ez = 12'(va) * 12'(vb) * 12'(vc);
        ec = CW'(lat);
      end
      exp_q.push_back({1'b0, ec, ez});
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k;
    int en_cnt;
    logic seen;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_mul_rst",   64'(mul_rst),   64'(1));
    check("rst_mul_en",    64'(mul_en),    64'(0));
    check("rst_mul_abc",   64'({mul_a, mul_b, mul_c}), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_z",         64'(z),         64'(0));
    check("rst_cycles",    64'(cycles),    64'(0));
    check("rst_err",       64'(err),       64'(0));

    // long run: 15*15*15 over 4096 cycles
    lat = 4096;
    drive_op(4'd15, 4'd15, 4'd15);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drain(5000);

    // zero operand bypass
    lat = 4;
    en_seen = 1'b0;
    drive_op(4'd0, 4'd7, 4'd9);
    @(posedge clk); #1 in_valid = 1'b0;
    k = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (out_valid) begin
        k = i;
        break;
      end
    end
    check("bypass_latency_ok", 64'(k >= 1 && k <= 2), 64'(1));
    wait_drain(20);
    check("bypass_no_mul_en", 64'(en_seen), 64'(0));

    // back-pressure: result held 10 cycles
    lat = 3;
    out_ready = 1'b0;
    drive_op(4'd3, 4'd5, 4'd2);
    @(posedge clk); #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_out_valid_seen", 64'(seen), 64'(1));
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_z",         64'(z),         64'(30));
      check("bp_in_ready",  64'(in_ready),  64'(0));
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_out_valid_drop", 64'(out_valid), 64'(0));
    check("bp_idle_in_ready",  64'(in_ready),  64'(1));
    check("bp_drained",        64'(exp_q.size()), 64'(0));
    out_ready = 1'b1;

    // reset mid-RUN discards the operation
    lat = 4096;
    drive_op(4'd15, 4'd15, 4'd15);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_mul_rst",   64'(mul_rst),   64'(1));
    check("midrst_mul_en",    64'(mul_en),    64'(0));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_z",         64'(z),         64'(0));
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    lat = 5;
    drive_op(4'd2, 4'd2, 4'd2);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drain(100);

    // timeout instance: mul_ov never arrives
    @(posedge clk); #1 to_in_valid = 1'b1;
    @(negedge clk);
    check("to_in_ready", 64'(to_in_ready), 64'(1));
    @(posedge clk); #1 to_in_valid = 1'b0;
    en_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (to_mul_en) en_cnt++;
      if (to_out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_out_valid", 64'(seen),      64'(1));
    check("to_en_cycles", 64'(en_cnt),    64'(16));
    check("to_err",       64'(to_err),    64'(1));
    check("to_cycles",    64'(to_cycles), 64'(16));
    @(posedge clk); #1 to_out_ready = 1'b1;
    @(posedge clk); #1 to_out_ready = 1'b0;
    @(negedge clk);
    check("to_back_idle", 64'(to_in_ready), 64'(1));

    // ten back-to-back random triples, in_valid held high
    lat = 3;
    n_out = 0;
    for (int i = 0; i < 10; i++) begin
      drive_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drain(200);
    check("b2b_count", 64'(n_out), 64'(10));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
